// File: rtl/vga_vram_arbiter_pkg.sv
// vga_vram_arbiter_pkg: shared types and constants for the VRAM arbiter
package vga_vram_arbiter_pkg;
  localparam int VGA_ADDR_W = 24;
  typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU} owner_t;
  typedef enum logic [1:0] {C_IDLE, C_PEND, C_ACK} cpu_state_t;
endpackage

// File: rtl/vga_vram_arbiter_if.sv
// vga_vram_arbiter_if: video, CPU and memory-port signals around the arbiter
interface vga_vram_arbiter_if;
  import vga_vram_arbiter_pkg::*;
  logic                  active;
  logic                  vid_req;
  logic [VGA_ADDR_W-1:0] vid_address_in;
  logic [7:0]            vid_data_out;
  logic                  vid_valid;
  logic                  cpu_req;
  logic                  cpu_we;
  logic [VGA_ADDR_W-1:0] cpu_address_in;
  logic [7:0]            cpu_wdata;
  logic [7:0]            cpu_rdata;
  logic                  cpu_ack;
  logic [VGA_ADDR_W-1:0] mem_address_out;
  logic [7:0]            mem_data_out;
  logic                  mem_we;
  logic                  mem_oe;
  logic [7:0]            mem_data_in;
  modport slave (
    input  active, vid_req, vid_address_in, cpu_req, cpu_we, cpu_address_in, cpu_wdata, mem_data_in,
    output vid_data_out, vid_valid, cpu_rdata, cpu_ack, mem_address_out, mem_data_out, mem_we, mem_oe
  );
  modport master (
    output active, vid_req, vid_address_in, cpu_req, cpu_we, cpu_address_in, cpu_wdata, mem_data_in,
    input  vid_data_out, vid_valid, cpu_rdata, cpu_ack, mem_address_out, mem_data_out, mem_we, mem_oe
  );
endinterface

// File: rtl/vga_vram_arbiter_tag_pipe.sv
// vga_vram_arbiter_tag_pipe: delays each issued owner tag so it lines up with returning read data
module vga_vram_arbiter_tag_pipe
  import vga_vram_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic   clk_in,
  input  logic   rst_in,
  input  owner_t i_tag,
  output owner_t o_tag
);
  owner_t r_pipe [DEPTH];
  owner_t w_src  [DEPTH];
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign w_src[g] = i_tag;
    end else begin : g_body
      assign w_src[g] = r_pipe[g-1];
    end
  end
  // shift tags one stage per cycle; reset empties the pipe so stale accesses never return
  always_ff @(posedge clk_in)
    for (int i = 0; i < DEPTH; i++) r_pipe[i] <= rst_in ? OWN_NONE : w_src[i];
  assign o_tag = r_pipe[DEPTH-1];
endmodule

// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: shares one VRAM port between video fetch (priority) and the CPU bus
module vga_vram_arbiter
  import vga_vram_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input logic               clk_in,
  input logic               rst_in,
  vga_vram_arbiter_if.slave bus
);
  logic                  w_vid_go;
  logic                  w_cpu_go;
  owner_t                w_own;
  owner_t                w_ret;
  owner_t                r_own;
  cpu_state_t            r_state;
  logic [VGA_ADDR_W-1:0] r_addr;
  logic [7:0]            r_wdata;
  logic                  r_we;
  logic                  r_oe;
  logic [7:0]            r_vid_data;
  logic                  r_vid_valid;
  logic [7:0]            r_cpu_rdata;
  logic                  r_cpu_ack;
  logic                  r_cpu_we;
  assign w_vid_go = bus.vid_req & ~bus.active;
  assign w_cpu_go = ~w_vid_go & bus.cpu_req & (r_state == C_IDLE);
  assign w_own    = w_vid_go ? OWN_VID : w_cpu_go ? OWN_CPU : OWN_NONE;
  // register the granted access onto the memory port; address and data hold when idle
  always_ff @(posedge clk_in)
    if (rst_in) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_oe    <= 1'b0;
      r_own   <= OWN_NONE;
    end else begin
      r_addr  <= w_vid_go ? bus.vid_address_in : w_cpu_go ? bus.cpu_address_in : r_addr;
      r_wdata <= w_cpu_go ? bus.cpu_wdata : r_wdata;
      r_we    <= w_cpu_go & bus.cpu_we;
      r_oe    <= w_vid_go | (w_cpu_go & ~bus.cpu_we);
      r_own   <= w_own;
    end
  vga_vram_arbiter_tag_pipe #(.DEPTH(MEM_LATENCY)) u_tag_pipe (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .i_tag  (r_own),
    .o_tag  (w_ret)
  );
  // video return path: only video-tagged data reaches the video output
  always_ff @(posedge clk_in)
    if (rst_in) begin
      r_vid_data  <= '0;
      r_vid_valid <= 1'b0;
    end else begin
      r_vid_valid <= w_ret == OWN_VID;
      r_vid_data  <= (w_ret == OWN_VID) ? bus.mem_data_in : r_vid_data;
    end
  // CPU FSM: one outstanding access, ack on tag return, one forced idle cycle after ack
  always_ff @(posedge clk_in)
    if (rst_in) begin
      r_state     <= C_IDLE;
      r_cpu_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_cpu_we    <= 1'b0;
    end else begin
      r_cpu_ack <= 1'b0;
      case (r_state)
        C_IDLE: if (w_cpu_go) begin
          r_state  <= C_PEND;
          r_cpu_we <= bus.cpu_we;
        end
        C_PEND: if (w_ret == OWN_CPU) begin
          r_state     <= C_ACK;
          r_cpu_ack   <= 1'b1;
          r_cpu_rdata <= r_cpu_we ? r_cpu_rdata : bus.mem_data_in;
        end
        default: r_state <= C_IDLE;
      endcase
    end
  assign bus.mem_address_out = r_addr;
  assign bus.mem_data_out    = r_wdata;
  assign bus.mem_we          = r_we;
  assign bus.mem_oe          = r_oe;
  assign bus.vid_data_out    = r_vid_data;
  assign bus.vid_valid       = r_vid_valid;
  assign bus.cpu_rdata       = r_cpu_rdata;
  assign bus.cpu_ack         = r_cpu_ack;
endmodule

// File: tb/tb_vga_vram_arbiter.sv
// tb_vga_vram_arbiter: directed checks of the arbiter at memory latency 1 and 3
module tb_vga_vram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;
  logic [7:0] p1, p3a, p3b, p3c;
  vga_vram_arbiter_if b1 ();
  vga_vram_arbiter_if b3 ();
  vga_vram_arbiter #(.MEM_LATENCY(1)) u1 (.clk_in(clk), .rst_in(rst), .bus(b1));
  vga_vram_arbiter #(.MEM_LATENCY(3)) u3 (.clk_in(clk), .rst_in(rst), .bus(b3));
  always #5 clk = ~clk;
  function automatic logic [7:0] mdata(input logic [23:0] a);
    return (a == 24'h000960) ? 8'h41 : a[7:0];
  endfunction
  always @(posedge clk) begin
    p1  <= b1.mem_oe ? mdata(b1.mem_address_out) : 8'h00;
    p3a <= b3.mem_oe ? mdata(b3.mem_address_out) : 8'h00;
    p3b <= p3a;
    p3c <= p3b;
  end
  assign b1.mem_data_in = p1;
  assign b3.mem_data_in = p3c;
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    b1.active = 0; b1.vid_req = 0; b1.vid_address_in = '0;
    b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_address_in = '0; b1.cpu_wdata = '0;
    b3.active = 0; b3.vid_req = 0; b3.vid_address_in = '0;
    b3.cpu_req = 0; b3.cpu_we = 0; b3.cpu_address_in = '0; b3.cpu_wdata = '0;
    cyc(); cyc();
    chk("rst_vid_valid", b1.vid_valid, 0);
    chk("rst_cpu_ack", b1.cpu_ack, 0);
    chk("rst_mem_oe", b1.mem_oe, 0);
    chk("rst_mem_we", b1.mem_we, 0);
    chk("rst_mem_addr", b1.mem_address_out, 0);
    chk("rst_vid_data", b1.vid_data_out, 0);
    chk("rst_cpu_rdata", b1.cpu_rdata, 0);
    rst = 0;
    // blanking: video request ignored, CPU read served
    b1.active = 1; b1.vid_req = 1; b1.vid_address_in = 24'h5;
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_address_in = 24'h000960;
    cyc();
    chk("blank_c1_oe", b1.mem_oe, 1);
    chk("blank_c1_addr", b1.mem_address_out, 24'h000960);
    chk("blank_c1_ack", b1.cpu_ack, 0);
    cyc();
    chk("blank_c2_ack", b1.cpu_ack, 0);
    chk("blank_c2_oe", b1.mem_oe, 0);
    cyc();
    chk("blank_c3_ack", b1.cpu_ack, 1);
    chk("blank_c3_rdata", b1.cpu_rdata, 8'h41);
    chk("blank_c3_vid_valid", b1.vid_valid, 0);
    b1.cpu_req = 0; b1.vid_req = 0; b1.active = 0;
    cyc();
    chk("blank_c4_ack", b1.cpu_ack, 0);
    chk("blank_c4_vid_valid", b1.vid_valid, 0);
    // contention: video holds the bus, CPU write waits
    b1.vid_req = 1; b1.vid_address_in = 24'h100;
    b1.cpu_req = 1; b1.cpu_we = 1; b1.cpu_address_in = 24'h000010; b1.cpu_wdata = 8'h12;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("cont_no_we", b1.mem_we, 0);
    end
    b1.vid_req = 0;
    cyc();
    chk("cont_we", b1.mem_we, 1);
    chk("cont_we_addr", b1.mem_address_out, 24'h000010);
    chk("cont_we_data", b1.mem_data_out, 8'h12);
    chk("cont_we_oe", b1.mem_oe, 0);
    b1.vid_req = 1;
    cyc();
    chk("cont_ack_early", b1.cpu_ack, 0);
    cyc();
    chk("cont_ack", b1.cpu_ack, 1);
    b1.cpu_req = 0; b1.cpu_we = 0; b1.vid_req = 0;
    cyc(); cyc(); cyc();
    // alternating video fetches with a pending CPU read
    b1.vid_req = 1; b1.vid_address_in = 24'h0;
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_address_in = 24'h20;
    cyc();
    chk("alt_c1_oe", b1.mem_oe, 1);
    chk("alt_c1_addr", b1.mem_address_out, 24'h0);
    b1.vid_req = 0;
    cyc();
    chk("alt_c2_oe", b1.mem_oe, 1);
    chk("alt_c2_addr", b1.mem_address_out, 24'h20);
    b1.vid_req = 1; b1.vid_address_in = 24'h1;
    cyc();
    chk("alt_c3_vid_valid", b1.vid_valid, 1);
    chk("alt_c3_vid_data", b1.vid_data_out, 8'h00);
    chk("alt_c3_ack", b1.cpu_ack, 0);
    b1.vid_req = 0;
    cyc();
    chk("alt_c4_ack", b1.cpu_ack, 1);
    chk("alt_c4_rdata", b1.cpu_rdata, 8'h20);
    chk("alt_c4_vid_valid", b1.vid_valid, 0);
    b1.cpu_req = 0; b1.vid_req = 1; b1.vid_address_in = 24'h2;
    cyc();
    chk("alt_c5_vid_valid", b1.vid_valid, 1);
    chk("alt_c5_vid_data", b1.vid_data_out, 8'h01);
    b1.vid_req = 0;
    cyc();
    chk("alt_c6_vid_valid", b1.vid_valid, 0);
    chk("alt_c6_addr", b1.mem_address_out, 24'h2);
    cyc();
    chk("alt_c7_vid_valid", b1.vid_valid, 1);
    chk("alt_c7_vid_data", b1.vid_data_out, 8'h02);
    chk("alt_c7_ack", b1.cpu_ack, 0);
    // latency 3: back-to-back video then a CPU read
    b3.vid_req = 1; b3.vid_address_in = 24'h3;
    cyc();
    chk("l3_c1_addr", b3.mem_address_out, 24'h3);
    b3.vid_address_in = 24'h4;
    cyc();
    chk("l3_c2_addr", b3.mem_address_out, 24'h4);
    b3.vid_req = 0; b3.cpu_req = 1; b3.cpu_we = 0; b3.cpu_address_in = 24'h30;
    cyc();
    chk("l3_c3_addr", b3.mem_address_out, 24'h30);
    cyc();
    chk("l3_c4_vid_valid", b3.vid_valid, 0);
    cyc();
    chk("l3_c5_vid_valid", b3.vid_valid, 1);
    chk("l3_c5_vid_data", b3.vid_data_out, 8'h03);
    chk("l3_c5_ack", b3.cpu_ack, 0);
    cyc();
    chk("l3_c6_vid_valid", b3.vid_valid, 1);
    chk("l3_c6_vid_data", b3.vid_data_out, 8'h04);
    chk("l3_c6_ack", b3.cpu_ack, 0);
    cyc();
    chk("l3_c7_ack", b3.cpu_ack, 1);
    chk("l3_c7_rdata", b3.cpu_rdata, 8'h30);
    chk("l3_c7_vid_valid", b3.vid_valid, 0);
    b3.cpu_req = 0;
    // reset while a CPU read is pending
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_address_in = 24'h44;
    cyc();
    chk("rstp_c1_oe", b1.mem_oe, 1);
    rst = 1;
    cyc();
    chk("rstp_c2_ack", b1.cpu_ack, 0);
    chk("rstp_c2_oe", b1.mem_oe, 0);
    chk("rstp_c2_we", b1.mem_we, 0);
    chk("rstp_c2_addr", b1.mem_address_out, 0);
    chk("rstp_c2_rdata", b1.cpu_rdata, 0);
    chk("rstp_c2_vid_valid", b1.vid_valid, 0);
    chk("rstp_c2_vid_data", b1.vid_data_out, 0);
    rst = 0;
    cyc();
    chk("rstp_c3_ack", b1.cpu_ack, 0);
    chk("rstp_c3_oe", b1.mem_oe, 1);
    chk("rstp_c3_addr", b1.mem_address_out, 24'h44);
    cyc();
    chk("rstp_c4_ack", b1.cpu_ack, 0);
    cyc();
    chk("rstp_c5_ack", b1.cpu_ack, 1);
    chk("rstp_c5_rdata", b1.cpu_rdata, 8'h44);
    b1.cpu_req = 0;
    cyc();
    // request held across the ack
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_address_in = 24'h55;
    cyc();
    chk("held_c1_oe", b1.mem_oe, 1);
    cyc();
    chk("held_c2_ack", b1.cpu_ack, 0);
    cyc();
    chk("held_c3_ack", b1.cpu_ack, 1);
    chk("held_c3_rdata", b1.cpu_rdata, 8'h55);
    cyc();
    chk("held_c4_ack", b1.cpu_ack, 0);
    chk("held_c4_oe", b1.mem_oe, 0);
    cyc();
    chk("held_c5_oe", b1.mem_oe, 1);
    chk("held_c5_addr", b1.mem_address_out, 24'h55);
    cyc();
    chk("held_c6_ack", b1.cpu_ack, 0);
    cyc();
    chk("held_c7_ack", b1.cpu_ack, 1);
    b1.cpu_req = 0;
    cyc();
    chk("held_c8_ack", b1.cpu_ack, 0);
    chk("held_c8_oe", b1.mem_oe, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
